axi_slave_regfile: RTL and testbench

Parametrised successor to the fixed 4-register AXI4 slave: an AXI4 memory-mapped register file of NUM_REGS words. Supports FIXED, INCR and WRAP bursts, narrow transfers, per-beat error responses and registered read data. It is the generic CSR/scratch endpoint behind the AXI interconnect. Write and read paths are independent FSMs sharing one register array.

---
 rtl/axi_pkg.sv | 40 ++++
 rtl/axi_burst_addr_gen.sv | 48 ++++
 rtl/axi_slave_regfile.sv | 241 ++++++++++++++++++++++++
 tb/tb_axi_slave_regfile.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 types for the register-file slave: burst/response encodings,
// per-burst control payload and FSM state encodings.
package axi_pkg;

   typedef enum logic [1:0] {
      FIXED = 2'd0,
      INCR  = 2'd1,
      WRAP  = 2'd2,
      RSVD  = 2'd3
   } burst_t;

   typedef enum logic [1:0] {
      OKAY   = 2'd0,
      EXOKAY = 2'd1,
      SLVERR = 2'd2,
      DECERR = 2'd3
   } resp_t;

   typedef struct packed {
      logic [7:0] len;
      logic [2:0] size;
      burst_t     burst;
   } burst_ctl_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } w_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_t;

   function automatic logic [7:0] size_bytes(input logic [2:0] size);
      return 8'(8'd1 << size);
   endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational per-beat address step, burst legality and register decode.
module axi_burst_addr_gen
   import axi_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           NUM_REGS   = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic [ADDR_WIDTH-1:0]       addr,
   input  burst_ctl_t                  ctl,
   output logic [ADDR_WIDTH-1:0]       next_addr_c,
   output logic                        beat_err_c,
   output logic [$clog2(NUM_REGS)-1:0] idx_c
);

   localparam int unsigned BYTES      = DATA_WIDTH / 8;
   localparam int unsigned LOG2_BYTES = $clog2(BYTES);
   localparam int unsigned IDX_W      = $clog2(NUM_REGS);
   localparam int unsigned SPAN       = NUM_REGS * BYTES;

   logic [ADDR_WIDTH-1:0] incr_addr;
   logic [ADDR_WIDTH-1:0] wrap_mask;
   logic [ADDR_WIDTH:0]   offset;
   logic                  burst_err;
   logic                  range_err;

   // Borrow bit of the offset flags addresses below the base.
   always_comb begin
      incr_addr = addr + ADDR_WIDTH'(size_bytes(ctl.size));
      wrap_mask = ((ADDR_WIDTH'(ctl.len) + ADDR_WIDTH'(1)) << ctl.size) - ADDR_WIDTH'(1);
      next_addr_c = addr;
      case (ctl.burst)
         INCR:    next_addr_c = incr_addr;
         WRAP:    next_addr_c = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
         default: next_addr_c = addr;
      endcase

      burst_err = (ctl.burst == RSVD) || (ctl.size > 3'(LOG2_BYTES)) ||
                  ((ctl.burst == WRAP) && !(ctl.len inside {8'd1, 8'd3, 8'd7, 8'd15}));

      offset     = {1'b0, addr} - {1'b0, BASE_ADDR};
      range_err  = offset[ADDR_WIDTH] || (offset[ADDR_WIDTH-1:0] >= ADDR_WIDTH'(SPAN));
      beat_err_c = burst_err | range_err;
      idx_c      = offset[LOG2_BYTES +: IDX_W];
   end

endmodule

// File: rtl/axi_slave_regfile.sv
// AXI4 register file of NUM_REGS words with independent write and read burst
// engines sharing one register array; read data is registered.
module axi_slave_regfile
   import axi_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ID_WIDTH   = 4,
   parameter int unsigned           NUM_REGS   = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   input  logic [ID_WIDTH-1:0]     AWID,
   input  logic [ADDR_WIDTH-1:0]   AWADDR,
   input  logic [7:0]              AWLEN,
   input  logic [2:0]              AWSIZE,
   input  logic [1:0]              AWBURST,
   input  logic                    AWVALID,
   output logic                    AWREADY,
   input  logic [DATA_WIDTH-1:0]   WDATA,
   input  logic [DATA_WIDTH/8-1:0] WSTRB,
   input  logic                    WLAST,
   input  logic                    WVALID,
   output logic                    WREADY,
   output logic [ID_WIDTH-1:0]     BID,
   output logic [1:0]              BRESP,
   output logic                    BVALID,
   input  logic                    BREADY,
   input  logic [ID_WIDTH-1:0]     ARID,
   input  logic [ADDR_WIDTH-1:0]   ARADDR,
   input  logic [7:0]              ARLEN,
   input  logic [2:0]              ARSIZE,
   input  logic [1:0]              ARBURST,
   input  logic                    ARVALID,
   output logic                    ARREADY,
   output logic [ID_WIDTH-1:0]     RID,
   output logic [DATA_WIDTH-1:0]   RDATA,
   output logic [1:0]              RRESP,
   output logic                    RLAST,
   output logic                    RVALID,
   input  logic                    RREADY
);

   localparam int unsigned BYTES = DATA_WIDTH / 8;
   localparam int unsigned IDX_W = $clog2(NUM_REGS);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   // ---------------- write path ----------------
   w_state_t              w_state, w_state_d;
   logic [ID_WIDTH-1:0]   aw_id;
   logic [ADDR_WIDTH-1:0] aw_addr;
   burst_ctl_t            aw_ctl;
   logic [7:0]            w_cnt;
   logic                  w_err;
   logic                  aw_hs, w_hs, w_end, w_mismatch, w_we;
   logic [ADDR_WIDTH-1:0] w_next_addr;
   logic                  w_beat_err;
   logic [IDX_W-1:0]      w_idx;

   axi_burst_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .BASE_ADDR  (BASE_ADDR)
   ) u_waddr (
      .addr        (aw_addr),
      .ctl         (aw_ctl),
      .next_addr_c (w_next_addr),
      .beat_err_c  (w_beat_err),
      .idx_c       (w_idx)
   );

   always_ff @(posedge ACLK) begin
      if (!ARESETn) w_state <= W_IDLE;
      else          w_state <= w_state_d;
   end

   // A beat ends the burst on WLAST or when the counter runs out, whichever is first.
   always_comb begin
      w_state_d  = w_state;
      aw_hs      = 1'b0;
      w_hs       = 1'b0;
      w_end      = 1'b0;
      w_mismatch = 1'b0;
      w_we       = 1'b0;
      case (w_state)
         W_IDLE: begin
            aw_hs = AWVALID && AWREADY;
            if (aw_hs) w_state_d = W_DATA;
         end
         W_DATA: begin
            w_hs = WVALID && WREADY;
            if (w_hs) begin
               w_we       = !w_beat_err;
               w_mismatch = WLAST ^ (w_cnt == 8'd0);
               w_end      = WLAST || (w_cnt == 8'd0);
               if (w_end) w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (BVALID && BREADY) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         AWREADY <= 1'b1;
         WREADY  <= 1'b0;
         BVALID  <= 1'b0;
         BID     <= '0;
         BRESP   <= OKAY;
         aw_id   <= '0;
         aw_addr <= '0;
         aw_ctl  <= '0;
         w_cnt   <= '0;
         w_err   <= 1'b0;
      end else begin
         AWREADY <= (w_state_d == W_IDLE);
         WREADY  <= (w_state_d == W_DATA);
         BVALID  <= (w_state_d == W_RESP);
         if (aw_hs) begin
            aw_id   <= AWID;
            aw_addr <= AWADDR;
            aw_ctl  <= '{len: AWLEN, size: AWSIZE, burst: burst_t'(AWBURST)};
            w_cnt   <= AWLEN;
            w_err   <= 1'b0;
         end
         if (w_hs) begin
            aw_addr <= w_next_addr;
            w_cnt   <= w_cnt - 8'd1;
            w_err   <= w_err | w_beat_err;
         end
         if (w_end) begin
            BID   <= aw_id;
            BRESP <= (w_err || w_beat_err || w_mismatch) ? SLVERR : OKAY;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (w_we) begin
         for (int unsigned b = 0; b < BYTES; b++)
            if (WSTRB[b]) regs[w_idx][8*b +: 8] <= WDATA[8*b +: 8];
      end
   end

   // ---------------- read path ----------------
   r_state_t              r_state, r_state_d;
   logic [ADDR_WIDTH-1:0] ar_addr;
   burst_ctl_t            ar_ctl;
   logic [7:0]            r_cnt;
   logic                  ar_hs, r_hs, r_load;
   logic [ADDR_WIDTH-1:0] rg_addr;
   burst_ctl_t            rg_ctl;
   logic [ADDR_WIDTH-1:0] r_next_addr;
   logic                  r_beat_err;
   logic [IDX_W-1:0]      r_idx;

   axi_burst_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .BASE_ADDR  (BASE_ADDR)
   ) u_raddr (
      .addr        (rg_addr),
      .ctl         (rg_ctl),
      .next_addr_c (r_next_addr),
      .beat_err_c  (r_beat_err),
      .idx_c       (r_idx)
   );

   always_ff @(posedge ACLK) begin
      if (!ARESETn) r_state <= R_IDLE;
      else          r_state <= r_state_d;
   end

   // Beat 0 decodes straight from the AR payload; later beats from the stepped address.
   always_comb begin
      r_state_d = r_state;
      ar_hs     = 1'b0;
      r_hs      = 1'b0;
      r_load    = 1'b0;
      rg_addr   = ar_addr;
      rg_ctl    = ar_ctl;
      case (r_state)
         R_IDLE: begin
            rg_addr = ARADDR;
            rg_ctl  = '{len: ARLEN, size: ARSIZE, burst: burst_t'(ARBURST)};
            ar_hs   = ARVALID && ARREADY;
            r_load  = ar_hs;
            if (ar_hs) r_state_d = R_DATA;
         end
         R_DATA: begin
            r_hs   = RVALID && RREADY;
            r_load = r_hs && !RLAST;
            if (r_hs && RLAST) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         ARREADY <= 1'b1;
         RVALID  <= 1'b0;
         RLAST   <= 1'b0;
         RID     <= '0;
         RDATA   <= '0;
         RRESP   <= OKAY;
         ar_addr <= '0;
         ar_ctl  <= '0;
         r_cnt   <= '0;
      end else begin
         ARREADY <= (r_state_d == R_IDLE);
         RVALID  <= (r_state_d == R_DATA);
         if (ar_hs) begin
            RID    <= ARID;
            ar_ctl <= rg_ctl;
            r_cnt  <= ARLEN;
            RLAST  <= (ARLEN == 8'd0);
         end else if (r_load) begin
            r_cnt <= r_cnt - 8'd1;
            RLAST <= (r_cnt == 8'd1);
         end else if (r_hs) begin
            RLAST <= 1'b0;
         end
         if (r_load) begin
            ar_addr <= r_next_addr;
            RDATA   <= r_beat_err ? '0 : regs[r_idx];
            RRESP   <= r_beat_err ? SLVERR : OKAY;
         end
      end
   end

endmodule

// File: tb/tb_axi_slave_regfile.sv
// Directed bench for axi_slave_regfile (32-bit data, 16 regs at 0x1000_0000).
module tb_axi_slave_regfile;

   localparam logic [31:0] BASE = 32'h1000_0000;

   logic        ACLK = 1'b0;
   logic        ARESETn = 1'b0;
   logic [3:0]  AWID = '0;
   logic [31:0] AWADDR = '0;
   logic [7:0]  AWLEN = '0;
   logic [2:0]  AWSIZE = '0;
   logic [1:0]  AWBURST = '0;
   logic        AWVALID = 1'b0;
   logic        AWREADY;
   logic [31:0] WDATA = '0;
   logic [3:0]  WSTRB = '0;
   logic        WLAST = 1'b0;
   logic        WVALID = 1'b0;
   logic        WREADY;
   logic [3:0]  BID;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY = 1'b0;
   logic [3:0]  ARID = '0;
   logic [31:0] ARADDR = '0;
   logic [7:0]  ARLEN = '0;
   logic [2:0]  ARSIZE = '0;
   logic [1:0]  ARBURST = '0;
   logic        ARVALID = 1'b0;
   logic        ARREADY;
   logic [3:0]  RID;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST;
   logic        RVALID;
   logic        RREADY = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [31:0] wr_data [16];
   logic [3:0]  wr_strb [16];
   logic [31:0] rd_data [16];
   logic [1:0]  rd_resp [16];
   logic        rd_last [16];
   logic [3:0]  rd_id;
   logic [1:0]  b_resp;
   logic [3:0]  b_id;

   axi_slave_regfile #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .ID_WIDTH   (4),
      .NUM_REGS   (16),
      .BASE_ADDR  (BASE)
   ) dut (
      .ACLK (ACLK), .ARESETn (ARESETn),
      .AWID (AWID), .AWADDR (AWADDR), .AWLEN (AWLEN), .AWSIZE (AWSIZE),
      .AWBURST (AWBURST), .AWVALID (AWVALID), .AWREADY (AWREADY),
      .WDATA (WDATA), .WSTRB (WSTRB), .WLAST (WLAST), .WVALID (WVALID), .WREADY (WREADY),
      .BID (BID), .BRESP (BRESP), .BVALID (BVALID), .BREADY (BREADY),
      .ARID (ARID), .ARADDR (ARADDR), .ARLEN (ARLEN), .ARSIZE (ARSIZE),
      .ARBURST (ARBURST), .ARVALID (ARVALID), .ARREADY (ARREADY),
      .RID (RID), .RDATA (RDATA), .RRESP (RRESP), .RLAST (RLAST), .RVALID (RVALID),
      .RREADY (RREADY)
   );

   always #5 ACLK = ~ACLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   // Sends nbeats of wr_data/wr_strb; WLAST goes high on beat last_idx.
   task automatic axi_write(input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [3:0] id, input int nbeats,
                            input int last_idx, input bit do_resp);
      logic rdy;
      int   t;
      AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
      AWVALID = 1'b1;
      t = 0;
      do begin rdy = AWREADY; tick(); t++; end while (!rdy && t < 50);
      AWVALID = 1'b0;
      check("aw_handshake", 64'(rdy), 64'd1);
      for (int i = 0; i < nbeats; i++) begin
         WDATA = wr_data[i]; WSTRB = wr_strb[i]; WLAST = (i == last_idx); WVALID = 1'b1;
         t = 0;
         do begin rdy = WREADY; tick(); t++; end while (!rdy && t < 50);
         check("w_handshake", 64'(rdy), 64'd1);
      end
      WVALID = 1'b0; WLAST = 1'b0;
      if (do_resp) begin
         BREADY = 1'b1;
         t = 0;
         do begin rdy = BVALID; b_resp = BRESP; b_id = BID; tick(); t++; end
            while (!rdy && t < 50);
         BREADY = 1'b0;
         check("b_handshake", 64'(rdy), 64'd1);
      end
   endtask

   // RREADY held high; records every beat and checks 1 beat/cycle streaming.
   task automatic axi_read(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [3:0] id);
      logic rdy;
      int   t;
      RREADY = 1'b1;
      ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
      ARVALID = 1'b1;
      t = 0;
      do begin rdy = ARREADY; tick(); t++; end while (!rdy && t < 50);
      ARVALID = 1'b0;
      check("ar_handshake", 64'(rdy), 64'd1);
      for (int i = 0; i <= int'(len); i++) begin
         check("rvalid_beat", 64'(RVALID), 64'd1);
         rd_data[i] = RDATA; rd_resp[i] = RRESP; rd_last[i] = RLAST; rd_id = RID;
         tick();
      end
      check("rvalid_drop", 64'(RVALID), 64'd0);
      RREADY = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) begin wr_data[i] = '0; wr_strb[i] = 4'hF; end

      // reset
      repeat (3) tick();
      ARESETn = 1'b1;
      tick();
      check("rst_awready", 64'(AWREADY), 64'd1);
      check("rst_arready", 64'(ARREADY), 64'd1);
      check("rst_wready",  64'(WREADY),  64'd0);
      check("rst_bvalid",  64'(BVALID),  64'd0);
      check("rst_rvalid",  64'(RVALID),  64'd0);
      check("rst_rlast",   64'(RLAST),   64'd0);
      check("rst_bid_rid", 64'({BID, RID}), 64'd0);
      check("rst_rdata",   64'(RDATA),   64'd0);
      check("rst_resps",   64'({BRESP, RRESP}), 64'd0);

      // single INCR write/read
      wr_data[0] = 32'hDEAD_BEEF;
      axi_write(BASE + 32'h4, 8'd0, 3'd2, 2'b01, 4'd3, 1, 0, 1'b1);
      check("single_bresp", 64'(b_resp), 64'd0);
      check("single_bid",   64'(b_id),   64'd3);
      axi_read(BASE + 32'h4, 8'd0, 3'd2, 2'b01, 4'd5);
      check("single_rdata", 64'(rd_data[0]), 64'hDEAD_BEEF);
      check("single_rlast", 64'(rd_last[0]), 64'd1);
      check("single_rresp", 64'(rd_resp[0]), 64'd0);
      check("single_rid",   64'(rd_id),      64'd5);

      // INCR LEN=3 from reg 0
      for (int i = 0; i < 4; i++) wr_data[i] = 32'(i + 1);
      axi_write(BASE, 8'd3, 3'd2, 2'b01, 4'd1, 4, 3, 1'b1);
      check("incr4_bresp", 64'(b_resp), 64'd0);
      axi_read(BASE, 8'd3, 3'd2, 2'b01, 4'd2);
      check("incr4_data",  64'({rd_data[0], rd_data[1]}), 64'h0000_0001_0000_0002);
      check("incr4_data2", 64'({rd_data[2], rd_data[3]}), 64'h0000_0003_0000_0004);
      check("incr4_rlast", 64'({rd_last[0], rd_last[1], rd_last[2], rd_last[3]}), 64'b0001);

      // WRAP LEN=3 from reg 2: regs 2,3,0,1
      axi_read(BASE + 32'h8, 8'd3, 3'd2, 2'b10, 4'd4);
      check("wrap_data",  64'({rd_data[0], rd_data[1]}), 64'h0000_0003_0000_0004);
      check("wrap_data2", 64'({rd_data[2], rd_data[3]}), 64'h0000_0001_0000_0002);
      check("wrap_resp",  64'({rd_resp[0], rd_resp[1], rd_resp[2], rd_resp[3]}), 64'd0);

      // byte strobes: bytes 0 and 2 replaced
      wr_data[0] = 32'h1122_3344; wr_strb[0] = 4'hF;
      axi_write(BASE + 32'h14, 8'd0, 3'd2, 2'b01, 4'd0, 1, 0, 1'b1);
      wr_data[0] = 32'hAABB_CCDD; wr_strb[0] = 4'h5;
      axi_write(BASE + 32'h14, 8'd0, 3'd2, 2'b01, 4'd0, 1, 0, 1'b1);
      wr_strb[0] = 4'hF;
      axi_read(BASE + 32'h14, 8'd0, 3'd2, 2'b01, 4'd0);
      check("strb_rdata", 64'(rd_data[0]), 64'h11BB_33DD);

      // burst running off the end of the map
      wr_data[0] = 32'hCAFE_0001; wr_data[1] = 32'hCAFE_0002;
      axi_write(BASE + 32'h3C, 8'd1, 3'd2, 2'b01, 4'd6, 2, 1, 1'b1);
      check("oob_bresp", 64'(b_resp), 64'd2);
      axi_read(BASE + 32'h3C, 8'd1, 3'd2, 2'b01, 4'd6);
      check("oob_rdata", 64'({rd_data[0], rd_data[1]}), 64'hCAFE_0001_0000_0000);
      check("oob_rresp", 64'({rd_resp[0], rd_resp[1]}), 64'b0010);
      check("oob_rlast", 64'({rd_last[0], rd_last[1]}), 64'b01);

      // early WLAST on a LEN=1 burst
      wr_data[0] = 32'h0000_0066;
      axi_write(BASE + 32'h18, 8'd1, 3'd2, 2'b01, 4'd7, 1, 0, 1'b1);
      check("early_wlast_bresp", 64'(b_resp), 64'd2);
      axi_read(BASE + 32'h18, 8'd0, 3'd2, 2'b01, 4'd7);
      check("early_wlast_data", 64'(rd_data[0]), 64'h66);

      // reserved burst type read
      axi_read(BASE, 8'd0, 3'd2, 2'b11, 4'd1);
      check("rsvd_rdata", 64'(rd_data[0]), 64'd0);
      check("rsvd_rresp", 64'(rd_resp[0]), 64'd2);

      // reset mid-burst
      wr_data[0] = 32'h88; wr_data[1] = 32'h99;
      axi_write(BASE + 32'h20, 8'd3, 3'd2, 2'b01, 4'd8, 2, -1, 1'b0);
      ARESETn = 1'b0;
      tick(); tick();
      ARESETn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("midrst_bvalid", 64'(BVALID), 64'd0);
      end
      check("midrst_awready", 64'(AWREADY), 64'd1);
      check("midrst_wready",  64'(WREADY),  64'd0);
      axi_read(BASE, 8'd0, 3'd2, 2'b01, 4'd0);
      check("midrst_reg0", 64'(rd_data[0]), 64'd0);
      axi_read(BASE + 32'h20, 8'd1, 3'd2, 2'b01, 4'd0);
      check("midrst_reg8_9", 64'({rd_data[0], rd_data[1]}), 64'd0);
      wr_data[0] = 32'h1234_5678;
      axi_write(BASE + 32'h20, 8'd0, 3'd2, 2'b01, 4'd2, 1, 0, 1'b1);
      check("post_rst_bresp", 64'(b_resp), 64'd0);
      axi_read(BASE + 32'h20, 8'd0, 3'd2, 2'b01, 4'd0);
      check("post_rst_rdata", 64'(rd_data[0]), 64'h1234_5678);

      // BREADY stall: response held stable
      wr_data[0] = 32'h0000_00AA;
      axi_write(BASE + 32'h28, 8'd0, 3'd2, 2'b01, 4'd9, 1, 0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         check("stall_bvalid", 64'(BVALID), 64'd1);
         check("stall_bid",    64'(BID),    64'd9);
         check("stall_bresp",  64'(BRESP),  64'd0);
         check("stall_awready", 64'(AWREADY), 64'd0);
         tick();
      end
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
      check("stall_bvalid_drop", 64'(BVALID), 64'd0);
      tick();
      check("stall_awready_back", 64'(AWREADY), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
